vga_capture: RTL and testbench

- VGA sink: the receiving end of the pixel stream produced by the display path (hsync/vsync/blank_n/RGB).
- Recovers pixel coordinates from the sync and valid signals and emits frame-buffer write beats (address + 24-bit RGB).
- Checks line and frame geometry; reports errors, lock and frame completion.
- Used for loopback self-test of the display chain and as a bench monitor. Runs on the pixel clock.

---
 rtl/vga_pkg.sv | 42 ++++
 rtl/vga_capture_crc16.sv | 33 +++
 rtl/vga_capture.sv | 184 ++++++++++++++++++
 tb/tb_vga_capture.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA capture block: 640x480 timing, capture states,
// pixel layout and a 24-bit-per-beat CRC-16-CCITT step.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEEK    = 2'd1,
        ST_CAPTURE = 2'd2
    } cap_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One beat of CRC-16-CCITT: 24 data bits folded in MSB first.
    function automatic logic [15:0] crc16_step24(input logic [15:0] crc,
                                                 input logic [23:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 23; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/vga_capture_crc16.sv
// Frame CRC accumulator: one 24-bit CRC-16-CCITT step per enabled beat,
// reloaded to the initial value on i_init.
module vga_capture_crc16
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [23:0] i_data,
    output logic [15:0] o_crc_next
);

    logic [15:0] r_crc;

    // o_crc_next already includes the current beat, so a frame close in the
    // same cycle as a write still sees that write.
    always_comb begin
        o_crc_next = r_crc;
        if (i_en) begin
            o_crc_next = crc16_step24(r_crc, i_data);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_init) begin
            r_crc <= CRC16_INIT;
        end else begin
            r_crc <= o_crc_next;
        end
    end

endmodule

// File: rtl/vga_capture.sv
// VGA sink: recovers pixel coordinates, emits frame-buffer writes and checks geometry.
// Optional frame CRC output (frame_crc) is built when VGA_CAPTURE_CRC_EN is defined.
module vga_capture
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int H_W      = 10,
    parameter int V_W      = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               err_clr,
    input  logic               vga_hsync,
    input  logic               vga_vsync,
    input  logic               vga_valid,
    input  logic [7:0]         vga_r,
    input  logic [7:0]         vga_g,
    input  logic [7:0]         vga_b,
    output logic               wr_en,
    output logic [H_W+V_W-1:0] wr_addr,
    output logic [23:0]        wr_data,
    output logic               frame_done,
    output logic               locked,
    output logic               line_err,
    output logic               frame_err,
    output logic               busy
`ifdef VGA_CAPTURE_CRC_EN
    ,
    output logic [15:0]        frame_crc
`endif
);

    localparam logic [H_W-1:0] C_H_ACT = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] C_V_ACT = V_W'(V_ACTIVE);

    logic       r_hs, r_vs, r_valid, r_vs_d, r_valid_d;
    pixel_t     r_pix;
    cap_state_t r_state, w_state_nxt;

    logic [H_W-1:0] r_h_cnt;
    logic [V_W-1:0] r_v_cnt;
    logic           r_frame_bad;

    logic           w_cap, w_vs_fall, w_valid_fall, w_pix, w_h_over, w_v_over;
    logic           w_wr, w_line_close, w_line_ev, w_close, w_frame_ev, w_bad, w_good;
    logic [V_W-1:0] w_v_line;

    // Stage 1: register the pins; edges are found against the previous stage-1 value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs      <= 1'b0;
            r_vs      <= 1'b0;
            r_valid   <= 1'b0;
            r_vs_d    <= 1'b0;
            r_valid_d <= 1'b0;
            r_pix     <= '0;
        end else begin
            r_hs      <= vga_hsync;
            r_vs      <= vga_vsync;
            r_valid   <= vga_valid;
            r_vs_d    <= r_vs;
            r_valid_d <= r_valid;
            r_pix.r   <= vga_r;
            r_pix.g   <= vga_g;
            r_pix.b   <= vga_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (enable) w_state_nxt = ST_SEEK;
            ST_SEEK:    if (w_vs_fall) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (w_vs_fall) w_state_nxt = enable ? ST_CAPTURE : ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_cap        = (r_state == ST_CAPTURE);
    assign w_vs_fall    = r_vs_d & ~r_vs;
    assign w_valid_fall = r_valid_d & ~r_valid;
    assign w_pix        = w_cap & r_valid;
    assign w_h_over     = (r_h_cnt >= C_H_ACT);
    assign w_v_over     = (r_v_cnt >= C_V_ACT);
    assign w_wr         = w_pix & ~w_h_over & ~w_v_over;
    assign w_line_close = w_cap & w_valid_fall;
    assign w_close      = w_cap & w_vs_fall;

    // The line is closed before the frame, so the frame check sees the bumped v_cnt.
    assign w_v_line   = (w_line_close && (r_v_cnt != '1)) ? r_v_cnt + V_W'(1) : r_v_cnt;
    assign w_line_ev  = (w_pix & (w_h_over | ~r_hs)) |
                        (w_line_close & (r_h_cnt != C_H_ACT));
    assign w_frame_ev = (w_pix & w_v_over) | (w_close & (w_v_line != C_V_ACT));
    assign w_bad      = r_frame_bad | w_line_ev | w_frame_ev;
    assign w_good     = w_close & ~w_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_frame_bad <= 1'b0;
        end else if (w_vs_fall) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_frame_bad <= 1'b0;
        end else if (w_cap) begin
            if (w_valid_fall) begin
                r_h_cnt <= '0;
            end else if (w_pix && (r_h_cnt != '1)) begin
                r_h_cnt <= r_h_cnt + H_W'(1);
            end
            r_v_cnt     <= w_v_line;
            r_frame_bad <= w_bad;
        end
    end

    // A new error outranks err_clr in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done <= 1'b0;
            locked     <= 1'b0;
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= w_good;
            line_err   <= w_line_ev | (line_err & ~err_clr);
            frame_err  <= w_frame_ev | (frame_err & ~err_clr);
            if (w_line_ev || w_frame_ev) begin
                locked <= 1'b0;
            end else if (w_good) begin
                locked <= 1'b1;
            end
        end
    end

    // Stage 2: write beat, two clocks after the pixel reaches the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= w_wr;
            if (w_wr) begin
                wr_addr <= {r_v_cnt, r_h_cnt};
                wr_data <= r_pix;
            end
        end
    end

    assign busy = w_cap;

`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] w_crc_next;

    vga_capture_crc16 u_crc (
        .clk        (clk),
        .rst        (rst),
        .i_init     (w_vs_fall),
        .i_en       (w_wr),
        .i_data     (r_pix),
        .o_crc_next (w_crc_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_crc <= '0;
        end else if (w_close) begin
            frame_crc <= w_crc_next;
        end
    end
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture with an 8x4 active window and a tiny behavioural VGA source.
module tb_vga_capture;
  localparam int H_ACT = 8;
  localparam int V_ACT = 4;
  localparam int H_W   = 10;
  localparam int V_W   = 9;
  localparam int AW    = H_W + V_W;
  localparam int W     = AW + 24;

  logic clk = 1'b0;
  logic rst, enable, err_clr, vga_hsync, vga_vsync, vga_valid;
  logic [7:0] vga_r, vga_g, vga_b;
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0] wr_data;
  logic frame_done, locked, line_err, frame_err, busy;
`ifdef VGA_CAPTURE_CRC_EN
  logic [15:0] frame_crc;
`endif

  vga_capture #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .H_W(H_W), .V_W(V_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .err_clr    (err_clr),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .vga_valid  (vga_valid),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .locked     (locked),
    .line_err   (line_err),
    .frame_err  (frame_err),
    .busy       (busy)
`ifdef VGA_CAPTURE_CRC_EN
    ,
    .frame_crc  (frame_crc)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int cyc     = 0;

  logic [W-1:0] exp_q[$];
  int           due_q[$];
  logic [W-1:0] mon_e;
  int           mon_due;

  logic [23:0] pv         = 24'h102030;
  logic        const_mode = 1'b0;
  int          corrupt_h  = -1;
  logic [15:0] ref_crc    = 16'hFFFF;
  logic [15:0] prev_ref   = 16'hFFFF;
  logic [15:0] zero_ref   = 16'h0000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_crc_beat(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 24; i++) begin
      if (r[15] != d[23-i]) r = (r << 1) ^ 16'h1021;
      else                  r = r << 1;
    end
    return r;
  endfunction

  // scoreboard
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_done) n_done++;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexp_wr", wr_en, 1'b0);
      end else begin
        mon_e   = exp_q.pop_front();
        mon_due = due_q.pop_front();
        check("wr_addr", wr_addr, mon_e[W-1:24]);
        check("wr_data", wr_data, mon_e[23:0]);
        check("wr_latency", cyc, mon_due);
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vga_valid = 1'b0; vga_hsync = 1'b1; vga_vsync = 1'b1;
    end
  endtask

  task automatic vsync_pulse();
    prev_ref = ref_crc;
    ref_crc  = 16'hFFFF;
    repeat (2) begin
      @(negedge clk);
      vga_valid = 1'b0; vga_hsync = 1'b1; vga_vsync = 1'b0;
    end
    idle(4);
  endtask

  task automatic send_line(input int len, input int v, input bit capt, input bit tail);
    logic [23:0]    px;
    logic [V_W-1:0] va;
    logic [H_W-1:0] ha;
    for (int h = 0; h < len; h++) begin
      @(negedge clk);
      if (const_mode) px = (v == 0 && h == corrupt_h) ? 24'h000001 : 24'h000000;
      else begin
        px = pv;
        pv = pv + 24'h010203;
      end
      vga_valid = 1'b1; vga_hsync = 1'b1; vga_vsync = 1'b1;
      {vga_r, vga_g, vga_b} = px;
      if (capt && h < H_ACT && v < V_ACT) begin
        va = V_W'(v);
        ha = H_W'(h);
        exp_q.push_back({va, ha, px});
        due_q.push_back(cyc + 2);
        ref_crc = ref_crc_beat(ref_crc, px);
      end
    end
    if (tail) begin
      @(negedge clk); vga_valid = 1'b0; vga_hsync = 1'b1;
      @(negedge clk); vga_hsync = 1'b0;
      idle(2);
    end
  endtask

  task automatic frame(input int nlines, input int odd_line, input int odd_len, input bit capt);
    for (int l = 0; l < nlines; l++)
      send_line((l == odd_line) ? odd_len : H_ACT, l, capt, 1'b1);
  endtask

  task automatic pulse_err_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset(input string step);
    check({step, ".wr_en"},      wr_en,      1'b0);
    check({step, ".wr_addr"},    wr_addr,    '0);
    check({step, ".wr_data"},    wr_data,    '0);
    check({step, ".frame_done"}, frame_done, 1'b0);
    check({step, ".locked"},     locked,     1'b0);
    check({step, ".line_err"},   line_err,   1'b0);
    check({step, ".frame_err"},  frame_err,  1'b0);
    check({step, ".busy"},       busy,       1'b0);
`ifdef VGA_CAPTURE_CRC_EN
    check({step, ".frame_crc"},  frame_crc,  '0);
`endif
  endtask

  task automatic check_status(input string step, input int done_e, input logic lock_e,
                              input logic lerr_e, input logic ferr_e, input logic busy_e);
    check({step, ".n_done"},    n_done,       done_e);
    check({step, ".locked"},    locked,       lock_e);
    check({step, ".line_err"},  line_err,     lerr_e);
    check({step, ".frame_err"}, frame_err,    ferr_e);
    check({step, ".busy"},      busy,         busy_e);
    check({step, ".q_empty"},   exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; err_clr = 1'b0;
    vga_hsync = 1'b1; vga_vsync = 1'b1; vga_valid = 1'b0;
    vga_r = 8'h00; vga_g = 8'h00; vga_b = 8'h00;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // nominal: two good frames
    enable = 1'b1;
    idle(3);
    vsync_pulse();
    check("t1.busy_after_seek", busy, 1'b1);
    frame(V_ACT, -1, H_ACT, 1'b1);
    vsync_pulse();
    check_status("t1a", 1, 1'b1, 1'b0, 1'b0, 1'b1);
    frame(V_ACT, -1, H_ACT, 1'b1);
    vsync_pulse();
    check_status("t1b", 2, 1'b1, 1'b0, 1'b0, 1'b1);

    // short line, then err_clr and a good frame
    frame(V_ACT, 2, 7, 1'b1);
    vsync_pulse();
    check_status("t2a", 2, 1'b0, 1'b1, 1'b0, 1'b1);
    pulse_err_clr();
    check("t2.line_err_clr", line_err, 1'b0);
    frame(V_ACT, -1, H_ACT, 1'b1);
    vsync_pulse();
    check_status("t2b", 3, 1'b1, 1'b0, 1'b0, 1'b1);

    // long line, then an extra line
    frame(V_ACT, 1, 9, 1'b1);
    vsync_pulse();
    check_status("t3a", 3, 1'b0, 1'b1, 1'b0, 1'b1);
    pulse_err_clr();
    frame(V_ACT + 1, -1, H_ACT, 1'b1);
    vsync_pulse();
    check_status("t3b", 3, 1'b0, 1'b0, 1'b1, 1'b1);
    pulse_err_clr();
    check("t3.frame_err_clr", frame_err, 1'b0);

    // enable dropped mid-frame, then raised mid-frame
    send_line(H_ACT, 0, 1'b1, 1'b1);
    send_line(H_ACT, 1, 1'b1, 1'b1);
    enable = 1'b0;
    send_line(H_ACT, 2, 1'b1, 1'b1);
    send_line(H_ACT, 3, 1'b1, 1'b1);
    vsync_pulse();
    check_status("t4a", 4, 1'b1, 1'b0, 1'b0, 1'b0);
    send_line(H_ACT, 0, 1'b0, 1'b1);
    send_line(H_ACT, 1, 1'b0, 1'b1);
    enable = 1'b1;
    idle(2);
    check("t4.busy_seek", busy, 1'b0);
    send_line(H_ACT, 2, 1'b0, 1'b1);
    send_line(H_ACT, 3, 1'b0, 1'b1);
    vsync_pulse();
    check_status("t4b", 4, 1'b1, 1'b0, 1'b0, 1'b1);
    frame(V_ACT, -1, H_ACT, 1'b1);
    vsync_pulse();
    check_status("t4c", 5, 1'b1, 1'b0, 1'b0, 1'b1);

    // reset at pixel {1,3}: pixel 3 never reaches the write port
    send_line(H_ACT, 0, 1'b1, 1'b1);
    send_line(4, 1, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; vga_valid = 1'b0;
    @(negedge clk);
    check_reset("t5.reset");
    void'(exp_q.pop_back());
    void'(due_q.pop_back());
    check("t5.q_empty", exp_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    frame(V_ACT, -1, H_ACT, 1'b0);
    check_status("t5a", 5, 1'b0, 1'b0, 1'b0, 1'b0);
    vsync_pulse();
    check("t5.busy_resume", busy, 1'b1);
    frame(V_ACT, -1, H_ACT, 1'b1);
    vsync_pulse();
    check_status("t5b", 6, 1'b1, 1'b0, 1'b0, 1'b1);

`ifdef VGA_CAPTURE_CRC_EN
    // frame CRC: constant zero frame, then one corrupted pixel
    const_mode = 1'b1;
    frame(V_ACT, -1, H_ACT, 1'b1);
    vsync_pulse();
    zero_ref = prev_ref;
    check("t6.crc_zero", frame_crc, zero_ref);
    corrupt_h = 3;
    frame(V_ACT, -1, H_ACT, 1'b1);
    vsync_pulse();
    check("t6.crc_corrupt", frame_crc, prev_ref);
    check("t6.crc_changed", frame_crc != zero_ref, 1'b1);
    check_status("t6", 8, 1'b1, 1'b0, 1'b0, 1'b1);
`endif

    idle(4);
    check("final.q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
